dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
- Sequences MEM-stage loads and stores onto a single-outstanding valid/ready data-memory bus.
- Generates the stall that freezes the EX/MEM pipeline register while an access is in flight.
- Aligns and sign/zero-extends load data per funct3 and returns it to the MEM/WB path.
- Flags misaligned accesses and bus timeouts.

Parameters:
- DATA_WIDTH, 32, data word width; only 32 is supported.
- BUS_ADDR_WIDTH, 32, byte address width.
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before the access is aborted; legal range 1..65535.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- mem_r  in  1  MEM-stage load request.
- mem_w  in  1  MEM-stage store request.
- addr  in  BUS_ADDR_WIDTH  byte address (ALU result).
- w_data  in  DATA_WIDTH  store data, already lane-shifted.
- w_strb  in  4  store byte strobes.
- funct3  in  3  load/store size code.
- stall  out  1  freezes the EX/MEM register and earlier stages.
- ld_data  out  DATA_WIDTH  formatted load result.
- ld_valid  out  1  one-cycle pulse when ld_data is valid.
- access_err  out  1  one-cycle pulse on a misaligned or timed-out access.
- bus_req_valid  out  1  request valid.
- bus_req_ready  in  1  request accepted.
- bus_req_we  out  1  1 = write, 0 = read.
- bus_req_addr  out  BUS_ADDR_WIDTH  word-aligned address {addr[31:2],2'b00}.
- bus_req_wdata  out  DATA_WIDTH  write data.
- bus_req_strb  out  4  write strobes; 4'b0000 on reads.
- bus_rsp_valid  in  1  response valid; no backpressure.
- bus_rsp_rdata  in  DATA_WIDTH  read data word.

Behaviour:
- Reset: state=IDLE; ld_data=0; ld_valid=0; access_err=0; bus_req_valid=0; bus_req_we=0; bus_req_addr=0; bus_req_wdata=0; bus_req_strb=0; timeout counter=0.
  - Reset asserted mid-access drops bus_req_valid immediately, with no handshake completion. Any response arriving later is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If mem_w: latch the request, we=1, go REQ.
  - Else if mem_r: latch the request, we=0, go REQ.
  - If mem_r and mem_w are both set, the store wins.
  - If the access is misaligned, go straight to DONE with the error flag set and issue no bus request. Misaligned means: halfword with addr[0]=1; word with addr[1:0]!=0; load funct3 011, 110 or 111.
- REQ: bus_req_valid=1; request fields held stable from the latched copy. Go to WAIT on bus_req_ready.
- WAIT:
  - On bus_rsp_valid, capture the formatted rdata (reads only) and go DONE.
  - bus_rsp_valid in any other state is ignored.
- Timeout:
  - A 16-bit counter clears on leaving IDLE and increments each cycle in REQ and WAIT.
  - When the counter reaches TIMEOUT, go DONE with the error flag set and ld_data=0. bus_req_valid drops.
- DONE:
  - stall=0.
  - ld_valid=1 for loads without error.
  - access_err=1 if the error flag is set.
  - Always go IDLE next cycle.
  - mem_r/mem_w still asserted in DONE belong to the completing instruction and must not relaunch.
- stall is combinational: (IDLE & (mem_r|mem_w)) | REQ | WAIT.
  - Minimum load/store stall is 3 cycles (IDLE, REQ with ready=1, WAIT with rsp in the following cycle). DONE is the release cycle.
  - A misaligned access stalls 1 cycle.
- Load formatting (lane = addr[1:0]):
  - LB 000: sign-extend byte[lane].
  - LH 001: sign-extend half[addr[1]].
  - LW 010: word.
  - LBU 100: zero-extend byte.
  - LHU 101: zero-extend half.
- ld_data holds its value until the next completed load.
- Store alignment uses funct3 000/001/010. The strobe and data are passed through unchanged.
- No accesses pending: stall=0, bus idle.

Test Plan:
1. Reset, then hold mem_r=mem_w=0 for 5 cycles -> every output 0, stall=0.
2. LW addr=0x100, ready=1 immediately, rsp one cycle later with rdata=0xDEADBEEF:
   - bus_req_addr=0x100, we=0.
   - stall high for exactly 3 cycles, then DONE with ld_valid=1 and ld_data=0xDEADBEEF.
3. LB addr=0x103, rdata=0x80123456 -> ld_data=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr=0x102 -> 0x00008012.
4. SW addr=0x200, w_data=0x11223344, strb=0xF, ready delayed 4 cycles:
   - bus_req_valid and all fields stable for 5 cycles.
   - ld_valid stays 0.
5. LW addr=0x102 (misaligned) -> no bus_req_valid, stall 1 cycle, access_err pulse, ld_valid=0.
6. Each of the following:
   - TIMEOUT=8 with no ready -> after 8 cycles in REQ: access_err=1, bus_req_valid drops, ld_data=0.
   - rst pulsed while in WAIT -> immediate IDLE; a late bus_rsp_valid is ignored.
   - mem_r=mem_w=1 -> we=1.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// Single-outstanding valid/ready data-memory bus between the MEM-stage
// access controller (master) and the data memory (slave).
interface dmem_access_ctrl_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BUS_ADDR_WIDTH = 32
) ();
    logic                      bus_req_valid;
    logic                      bus_req_ready;
    logic                      bus_req_we;
    logic [BUS_ADDR_WIDTH-1:0] bus_req_addr;
    logic [DATA_WIDTH-1:0]     bus_req_wdata;
    logic [3:0]                bus_req_strb;
    logic                      bus_rsp_valid;
    logic [DATA_WIDTH-1:0]     bus_rsp_rdata;

    modport master (
        output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_strb,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata
    );

    modport slave (
        input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_strb,
        output bus_req_ready, bus_rsp_valid, bus_rsp_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store sequencer: drives one data-memory access at a time,
// stalls the pipeline while it is in flight and formats returned load data.
module dmem_access_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BUS_ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_r,
    input  logic                      mem_w,
    input  logic [BUS_ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]     w_data,
    input  logic [3:0]                w_strb,
    input  logic [2:0]                funct3,
    output logic                      stall,
    output logic [DATA_WIDTH-1:0]     ld_data,
    output logic                      ld_valid,
    output logic                      access_err,
    dmem_access_ctrl_if.master        dbus
);

    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] to_cnt;
    logic [2:0]       funct3_q;
    logic [1:0]       lane_q;

    // Stores only accept sb/sh/sw; loads reject the unused size codes.
    function automatic logic is_misaligned(input logic is_store, input logic [2:0] f3,
                                           input logic [1:0] lane);
        logic mis;
        case (f3)
            3'b000:  mis = 1'b0;
            3'b001:  mis = lane[0];
            3'b010:  mis = |lane;
            3'b100:  mis = is_store;
            3'b101:  mis = is_store | lane[0];
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fmt_load(input logic [2:0] f3,
                                                       input logic [1:0] lane,
                                                       input logic [DATA_WIDTH-1:0] rdata);
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        b = rdata[{lane, 3'b000} +: 8];
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = rdata;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign stall = ((state == S_IDLE) && (mem_r || mem_w)) ||
                   (state == S_REQ) || (state == S_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_IDLE;
            to_cnt             <= '0;
            funct3_q           <= '0;
            lane_q             <= '0;
            ld_data            <= '0;
            ld_valid           <= 1'b0;
            access_err         <= 1'b0;
            dbus.bus_req_valid <= 1'b0;
            dbus.bus_req_we    <= 1'b0;
            dbus.bus_req_addr  <= '0;
            dbus.bus_req_wdata <= '0;
            dbus.bus_req_strb  <= '0;
        end else begin
            ld_valid   <= 1'b0;
            access_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_r || mem_w) begin
                        to_cnt   <= '0;
                        funct3_q <= funct3;
                        lane_q   <= addr[1:0];
                        if (is_misaligned(mem_w, funct3, addr[1:0])) begin
                            state      <= S_DONE;
                            access_err <= 1'b1;
                        end else begin
                            // Store wins when both requests are raised.
                            state              <= S_REQ;
                            dbus.bus_req_valid <= 1'b1;
                            dbus.bus_req_we    <= mem_w;
                            dbus.bus_req_addr  <= {addr[BUS_ADDR_WIDTH-1:2], 2'b00};
                            dbus.bus_req_wdata <= mem_w ? w_data : '0;
                            dbus.bus_req_strb  <= mem_w ? w_strb : 4'b0000;
                        end
                    end
                end
                S_REQ: begin
                    to_cnt <= CNT_W'(to_cnt + 1'b1);
                    if (to_cnt == TO_LAST) begin
                        state              <= S_DONE;
                        access_err         <= 1'b1;
                        ld_data            <= '0;
                        dbus.bus_req_valid <= 1'b0;
                    end else if (dbus.bus_req_ready) begin
                        state              <= S_WAIT;
                        dbus.bus_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    to_cnt <= CNT_W'(to_cnt + 1'b1);
                    if (to_cnt == TO_LAST) begin
                        state      <= S_DONE;
                        access_err <= 1'b1;
                        ld_data    <= '0;
                    end else if (dbus.bus_rsp_valid) begin
                        state <= S_DONE;
                        if (!dbus.bus_req_we) begin
                            ld_data  <= fmt_load(funct3_q, lane_q, dbus.bus_rsp_rdata);
                            ld_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // Requests still visible here belong to the finishing instruction.
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
